// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI init/read controller.
// Holds the state encoding, the command frames, the s_cyc field layout
// and the READ frame builder.
package sd_spi_pkg;

  localparam int unsigned FRAME_W = 48;
  localparam int unsigned CYC_W   = 80;

  typedef enum logic [2:0] {
    ST_RST, ST_CMD0, ST_CMD8, ST_ACMD41, ST_CMD58, ST_READY, ST_READ, ST_FAIL
  } state_t;

  typedef enum logic {PH_SETUP, PH_RUN} phase_t;

  // Session cycle budget; the first field ("wait") sits in the MSBs.
  typedef struct packed {
    logic [7:0] wt;
    logic [7:0] pre;
    logic [7:0] start;
    logic [7:0] cmd;
    logic [7:0] cmdr;
    logic [7:0] acmd;
    logic [7:0] acmdr;
    logic [7:0] mid;
    logic [7:0] stop;
    logic [7:0] re;
  } cyc_t;

  localparam logic [FRAME_W-1:0] FRM_IDLE       = 48'hFFFF_FFFF_FFFF;
  localparam logic [FRAME_W-1:0] FRM_CMD0       = 48'h40_0000_0000_95;
  localparam logic [FRAME_W-1:0] FRM_CMD8       = 48'h48_0000_01AA_87;
  localparam logic [FRAME_W-1:0] FRM_CMD55      = 48'h77_0000_0000_65;
  localparam logic [FRAME_W-1:0] FRM_ACMD41_HCS = 48'h69_4000_0000_77;
  localparam logic [FRAME_W-1:0] FRM_ACMD41_V1  = 48'h69_0000_0000_E5;
  localparam logic [FRAME_W-1:0] FRM_CMD58      = 48'h7A_0000_0000_FD;

  localparam cyc_t CYC_CMD0   = '{wt: 8'd0, pre: 8'd10, start: 8'd1, cmd: 8'd6, cmdr: 8'd0,
                                  acmd: 8'd0, acmdr: 8'd0, mid: 8'd0, stop: 8'd1, re: 8'd1};
  localparam cyc_t CYC_CMD8   = '{wt: 8'd0, pre: 8'd0, start: 8'd1, cmd: 8'd6, cmdr: 8'd4,
                                  acmd: 8'd0, acmdr: 8'd0, mid: 8'd0, stop: 8'd1, re: 8'd1};
  localparam cyc_t CYC_ACMD41 = '{wt: 8'd0, pre: 8'd0, start: 8'd1, cmd: 8'd6, cmdr: 8'd0,
                                  acmd: 8'd6, acmdr: 8'd0, mid: 8'd0, stop: 8'd1, re: 8'd1};
  localparam cyc_t CYC_CMD58  = '{wt: 8'd0, pre: 8'd0, start: 8'd1, cmd: 8'd6, cmdr: 8'd4,
                                  acmd: 8'd0, acmdr: 8'd0, mid: 8'd0, stop: 8'd1, re: 8'd1};
  localparam cyc_t CYC_READ   = '{wt: 8'd0, pre: 8'd0, start: 8'd1, cmd: 8'd6, cmdr: 8'd0,
                                  acmd: 8'd0, acmdr: 8'd0, mid: 8'd255, stop: 8'd1, re: 8'd1};

  localparam logic [7:0] R1_IDLE  = 8'h01;
  localparam logic [7:0] R1_OK    = 8'h00;
  localparam logic [7:0] TOK_DATA = 8'hFE;

  // CMD17 frame: block-addressed cards take the sector, byte-addressed take sector*512.
  function automatic logic [FRAME_W-1:0] read_frame(input logic [31:0] sector, input logic hc);
    logic [31:0] arg;
    arg = hc ? sector : {sector[22:0], 9'd0};
    return {8'h51, arg, 8'hFF};
  endfunction

endpackage

// File: rtl/sd_spi_ctrl.sv
// SD-card SPI controller: card init (CMD0/CMD8/ACMD41/CMD58) then single
// sector reads, driving an external spi_session through the s_* ports.
// Ports: clk/rst; rd_* request/ack/completion and byte stream; init status;
// s_start/s_clkdiv/s_cmd/s_acmd/s_cyc session setup; s_done and responses back.
module sd_spi_ctrl
  import sd_spi_pkg::*;
#(
  parameter int unsigned CLKDIV_SLOW = 124,
  parameter int unsigned CLKDIV_FAST = 1,
  parameter int unsigned ACMD41_MAX  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req,
  input  logic [31:0]        rd_addr,
  output logic               rd_ack,
  output logic               busy,
  output logic               rd_done,
  output logic               rd_err,
  output logic               rd_valid,
  output logic [8:0]         rd_idx,
  output logic [7:0]         rd_data,
  output logic               init_done,
  output logic               init_err,
  output logic               sdhc,
  output logic               s_start,
  output logic [31:0]        s_clkdiv,
  output logic [FRAME_W-1:0] s_cmd,
  output logic [FRAME_W-1:0] s_acmd,
  output logic [CYC_W-1:0]   s_cyc,
  input  logic               s_done,
  input  logic [7:0]         s_cmdrsp,
  input  logic [7:0]         s_acmdrsp,
  input  logic [7:0]         s_rwrsp,
  input  logic [FRAME_W-1:0] s_cmdres,
  input  logic               s_rvalid,
  input  logic [15:0]        s_rindex,
  input  logic [7:0]         s_rdata
);

  state_t               r_state, w_state_nxt;
  phase_t               r_phase, w_phase_nxt;
  logic [2:0]           r_cmd0_cnt, w_cmd0_cnt_nxt;
  logic [31:0]          r_acmd_cnt, w_acmd_cnt_nxt;
  logic                 r_v2, w_v2_nxt;
  logic                 r_sdhc, w_sdhc_nxt;
  logic                 w_rd_done_nxt, w_rd_err_nxt;
  logic                 w_is_cmd, w_load;
  logic [FRAME_W-1:0]   w_frm_cmd, w_frm_acmd;
  cyc_t                 w_frm_cyc;
  logic [31:0]          w_frm_div;
  logic                 r_s_start, r_busy, r_init_done, r_init_err, r_rd_done, r_rd_err;
  logic [31:0]          r_s_clkdiv;
  logic [FRAME_W-1:0]   r_s_cmd, r_s_acmd;
  logic [CYC_W-1:0]     r_s_cyc;
  logic                 r_rd_valid;
  logic [8:0]           r_rd_idx;
  logic [7:0]           r_rd_data;
  logic                 w_unused;

  // Only the R7 check pattern and the OCR CCS bit of the response are consumed.
  assign w_unused = &{1'b0, s_cmdres[47:31], s_cmdres[29:12]};

  assign w_is_cmd = (r_state inside {ST_CMD0, ST_CMD8, ST_ACMD41, ST_CMD58, ST_READ});
  assign rd_ack   = (r_state == ST_READY) && rd_req;

  // Next-state, response evaluation and frame selection for the next session.
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_cmd0_cnt_nxt = r_cmd0_cnt;
    w_acmd_cnt_nxt = r_acmd_cnt;
    w_v2_nxt       = r_v2;
    w_sdhc_nxt     = r_sdhc;
    w_rd_done_nxt  = 1'b0;
    w_rd_err_nxt   = 1'b0;
    w_load         = 1'b0;
    w_frm_cmd      = FRM_IDLE;
    w_frm_acmd     = FRM_IDLE;
    w_frm_cyc      = '0;
    w_frm_div      = 32'(CLKDIV_SLOW);

    if (w_is_cmd && r_phase == PH_SETUP) begin
      w_phase_nxt = PH_RUN;
    end else if (w_is_cmd && s_done) begin
      w_phase_nxt = PH_SETUP;
      case (r_state)
        ST_CMD0: begin
          if (s_cmdrsp == R1_IDLE)   w_state_nxt = ST_CMD8;
          else if (r_cmd0_cnt == 3'd7) w_state_nxt = ST_FAIL;
          else                        w_cmd0_cnt_nxt = r_cmd0_cnt + 3'd1;
        end
        ST_CMD8: begin
          if (s_cmdrsp == R1_IDLE && s_cmdres[11:0] == 12'h1AA) begin
            w_v2_nxt    = 1'b1;
            w_state_nxt = ST_ACMD41;
          end else if (s_cmdrsp[2]) begin
            w_v2_nxt    = 1'b0;
            w_state_nxt = ST_ACMD41;
          end else begin
            w_state_nxt = ST_FAIL;
          end
        end
        ST_ACMD41: begin
          if (s_acmdrsp == R1_OK) begin
            w_state_nxt = r_v2 ? ST_CMD58 : ST_READY;
            if (!r_v2) w_sdhc_nxt = 1'b0;
          end else if (s_acmdrsp != R1_IDLE || r_acmd_cnt == 32'(ACMD41_MAX - 1)) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_acmd_cnt_nxt = r_acmd_cnt + 32'd1;
          end
        end
        ST_CMD58: begin
          if (s_cmdrsp == R1_OK) begin
            w_sdhc_nxt  = s_cmdres[30];
            w_state_nxt = ST_READY;
          end else begin
            w_state_nxt = ST_FAIL;
          end
        end
        ST_READ: begin
          w_rd_done_nxt = 1'b1;
          w_rd_err_nxt  = !(s_cmdrsp == R1_OK && s_rwrsp == TOK_DATA);
          w_state_nxt   = ST_READY;
        end
        default: ;
      endcase
    end else if (r_state == ST_RST) begin
      w_state_nxt = ST_CMD0;
      w_phase_nxt = PH_SETUP;
    end else if (rd_ack) begin
      w_state_nxt = ST_READ;
      w_phase_nxt = PH_SETUP;
    end

    // Session fields are loaded only when entering a command's SETUP phase.
    if (w_phase_nxt == PH_SETUP) begin
      case (w_state_nxt)
        ST_CMD0:   begin w_load = 1'b1; w_frm_cmd = FRM_CMD0;  w_frm_cyc = CYC_CMD0;  end
        ST_CMD8:   begin w_load = 1'b1; w_frm_cmd = FRM_CMD8;  w_frm_cyc = CYC_CMD8;  end
        ST_ACMD41: begin
          w_load     = 1'b1;
          w_frm_cmd  = FRM_CMD55;
          w_frm_acmd = w_v2_nxt ? FRM_ACMD41_HCS : FRM_ACMD41_V1;
          w_frm_cyc  = CYC_ACMD41;
        end
        ST_CMD58:  begin w_load = 1'b1; w_frm_cmd = FRM_CMD58; w_frm_cyc = CYC_CMD58; end
        ST_READ: begin
          w_load    = 1'b1;
          w_frm_cmd = read_frame(rd_addr, r_sdhc);
          w_frm_cyc = CYC_READ;
          w_frm_div = 32'(CLKDIV_FAST);
        end
        default: ;
      endcase
    end
  end

  // FSM state and session-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RST;
      r_phase     <= PH_SETUP;
      r_cmd0_cnt  <= 3'd0;
      r_acmd_cnt  <= 32'd0;
      r_v2        <= 1'b0;
      r_sdhc      <= 1'b0;
      r_s_start   <= 1'b0;
      r_s_clkdiv  <= 32'(CLKDIV_SLOW);
      r_s_cmd     <= FRM_IDLE;
      r_s_acmd    <= FRM_IDLE;
      r_s_cyc     <= '0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_rd_done   <= 1'b0;
      r_rd_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_cmd0_cnt  <= w_cmd0_cnt_nxt;
      r_acmd_cnt  <= w_acmd_cnt_nxt;
      r_v2        <= w_v2_nxt;
      r_sdhc      <= w_sdhc_nxt;
      r_s_start   <= (w_phase_nxt == PH_RUN);
      if (w_load) begin
        r_s_clkdiv <= w_frm_div;
        r_s_cmd    <= w_frm_cmd;
        r_s_acmd   <= w_frm_acmd;
        r_s_cyc    <= w_frm_cyc;
      end
      r_busy      <= (w_state_nxt != ST_READY);
      r_init_done <= r_init_done | (w_state_nxt == ST_READY);
      r_init_err  <= r_init_err | (w_state_nxt == ST_FAIL);
      r_rd_done   <= w_rd_done_nxt;
      r_rd_err    <= w_rd_err_nxt;
    end
  end

  // Sector byte stream: session counts down 513..0, the last two are CRC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_idx   <= 9'd0;
      r_rd_data  <= 8'd0;
    end else begin
      r_rd_valid <= 1'b0;
      if (r_state == ST_READ && s_rvalid && s_rindex >= 16'd2 && s_rindex <= 16'd513) begin
        r_rd_valid <= 1'b1;
        r_rd_idx   <= 9'(16'd513 - s_rindex);
        r_rd_data  <= s_rdata;
      end
    end
  end

  assign busy      = r_busy;
  assign rd_done   = r_rd_done;
  assign rd_err    = r_rd_err;
  assign rd_valid  = r_rd_valid;
  assign rd_idx    = r_rd_idx;
  assign rd_data   = r_rd_data;
  assign init_done = r_init_done;
  assign init_err  = r_init_err;
  assign sdhc      = r_sdhc;
  assign s_start   = r_s_start;
  assign s_clkdiv  = r_s_clkdiv;
  assign s_cmd     = r_s_cmd;
  assign s_acmd    = r_s_acmd;
  assign s_cyc     = r_s_cyc;

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Bench for sd_spi_ctrl: a behavioural spi_session + card model answers each
// session; sector bytes are queued when emitted and checked as rd_valid beats.
module tb_sd_spi_ctrl;

  logic        clk, rst, rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack, busy, rd_done, rd_err, rd_valid;
  logic [8:0]  rd_idx;
  logic [7:0]  rd_data;
  logic        init_done, init_err, sdhc, s_start;
  logic [31:0] s_clkdiv;
  logic [47:0] s_cmd, s_acmd, s_cmdres;
  logic [79:0] s_cyc;
  logic        s_done, s_rvalid;
  logic [7:0]  s_cmdrsp, s_acmdrsp, s_rwrsp, s_rdata;
  logic [15:0] s_rindex;

  sd_spi_ctrl dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .busy(busy), .rd_done(rd_done), .rd_err(rd_err), .rd_valid(rd_valid),
    .rd_idx(rd_idx), .rd_data(rd_data), .init_done(init_done), .init_err(init_err),
    .sdhc(sdhc), .s_start(s_start), .s_clkdiv(s_clkdiv), .s_cmd(s_cmd),
    .s_acmd(s_acmd), .s_cyc(s_cyc), .s_done(s_done), .s_cmdrsp(s_cmdrsp),
    .s_acmdrsp(s_acmdrsp), .s_rwrsp(s_rwrsp), .s_cmdres(s_cmdres),
    .s_rvalid(s_rvalid), .s_rindex(s_rindex), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // card configuration
  int         cfg_cmd0_fail_n, cfg_busy_n;
  bit         cfg_v1, cfg_ocr30;
  logic [7:0] cfg_token;

  // session log
  int          n_cmd0, n_acmd41, n_cmd58, n_read;
  logic [31:0] last_read_arg, last_read_div;
  logic [79:0] last_read_cyc;
  logic [47:0] last_acmd;

  logic [16:0] sb_q[$];
  int          beat_cnt;

  logic [1:0] m_ph;
  int         m_cnt;
  logic [7:0] m_cmd;

  // session + card model
  always @(posedge clk) begin
    s_done   <= 1'b0;
    s_rvalid <= 1'b0;
    if (rst) begin
      m_ph <= 2'd0;
      n_cmd0 = 0; n_acmd41 = 0; n_cmd58 = 0; n_read = 0;
      s_rindex <= 16'd0; s_rdata <= 8'd0;
      s_cmdrsp <= 8'hFF; s_acmdrsp <= 8'hFF; s_rwrsp <= 8'hFF; s_cmdres <= '1;
    end else begin
      case (m_ph)
        2'd0: if (s_start) begin
          m_cmd = s_cmd[47:40];
          m_cnt = 0;
          m_ph <= 2'd1;
          if (m_cmd == 8'h51) begin
            last_read_arg = s_cmd[39:8];
            last_read_cyc = s_cyc;
            last_read_div = s_clkdiv;
          end
          if (m_cmd == 8'h77) last_acmd = s_acmd;
        end
        2'd1: begin
          if (m_cmd == 8'h51 && m_cnt < 514) begin
            s_rvalid <= 1'b1;
            s_rindex <= 16'(513 - m_cnt);
            s_rdata  <= (m_cnt < 512) ? 8'(m_cnt) : 8'hC5;
            if (m_cnt < 512) sb_q.push_back({9'(m_cnt), 8'(m_cnt)});
            m_cnt++;
          end else if (m_cmd != 8'h51 && m_cnt < 3) begin
            m_cnt++;
          end else begin
            s_done <= 1'b1;
            m_ph   <= 2'd2;
            case (m_cmd)
              8'h40: begin
                s_cmdrsp <= (n_cmd0 < cfg_cmd0_fail_n) ? 8'hFF : 8'h01;
                n_cmd0++;
              end
              8'h48: begin
                s_cmdrsp <= cfg_v1 ? 8'h05 : 8'h01;
                s_cmdres <= cfg_v1 ? 48'h05_0000_0000_00 : 48'h00_0100_0001_AA;
              end
              8'h77: begin
                s_cmdrsp  <= 8'h01;
                s_acmdrsp <= (n_acmd41 < cfg_busy_n) ? 8'h01 : 8'h00;
                n_acmd41++;
              end
              8'h7A: begin
                s_cmdrsp <= 8'h00;
                s_cmdres <= {16'h0000, cfg_ocr30 ? 32'hC0FF_8000 : 32'h80FF_8000};
                n_cmd58++;
              end
              8'h51: begin
                s_cmdrsp <= 8'h00;
                s_rwrsp  <= cfg_token;
                n_read++;
              end
              default: s_cmdrsp <= 8'hFF;
            endcase
          end
        end
        default: if (!s_start) m_ph <= 2'd0;
      endcase
    end
  end

  // scoreboard: every delivered byte must match the oldest emitted one
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb_q.size() == 0) chk("sb_underflow", 80'(sb_q.size()), 80'd1);
      else chk("rd_beat", {rd_idx, rd_data}, 80'(sb_q.pop_front()));
      beat_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_init();
    for (int t = 0; t < 4000; t++) begin
      if (init_done || init_err) break;
      @(negedge clk);
    end
    chk("init_finished", 80'(init_done | init_err), 80'd1);
  endtask

  task automatic do_read(input logic [31:0] sec, input logic exp_err);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = sec; beat_cnt = 0;
    #1;
    chk("rd_ack_ready", 80'(rd_ack), 80'd1);
    chk("busy_ready", 80'(busy), 80'd0);
    @(negedge clk);
    chk("rd_ack_ignored", 80'(rd_ack), 80'd0);
    chk("busy_read", 80'(busy), 80'd1);
    rd_req = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (rd_done) break;
    end
    chk("rd_done_seen", 80'(rd_done), 80'd1);
    chk("rd_err", 80'(rd_err), 80'(exp_err));
    chk("busy_back_ready", 80'(busy), 80'd0);
    chk("beat_count", 80'(beat_cnt), 80'd512);
    chk("sb_drained", 80'(sb_q.size()), 80'd0);
    chk("read_div", 80'(last_read_div), 80'd1);
    chk("read_cyc", last_read_cyc,
        {8'd0, 8'd0, 8'd1, 8'd6, 8'd0, 8'd0, 8'd0, 8'd255, 8'd1, 8'd1});
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = 32'd0; beat_cnt = 0;
    cfg_cmd0_fail_n = 0; cfg_busy_n = 2; cfg_v1 = 1'b0; cfg_ocr30 = 1'b1; cfg_token = 8'hFE;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_busy", 80'(busy), 80'd1);
    chk("rst_start", 80'(s_start), 80'd0);
    chk("rst_clkdiv", 80'(s_clkdiv), 80'd124);
    chk("rst_cmd", 80'(s_cmd), 80'hFFFF_FFFF_FFFF);
    chk("rst_acmd", 80'(s_acmd), 80'hFFFF_FFFF_FFFF);
    chk("rst_cyc", s_cyc, 80'd0);
    chk("rst_init", 80'({init_done, init_err, sdhc}), 80'd0);

    // SDHC card: first cycle after release is CMD0 SETUP
    rst = 1'b0;
    @(negedge clk);
    chk("cmd0_frame", 80'(s_cmd), 80'h40_0000_0000_95);
    chk("cmd0_setup_start", 80'(s_start), 80'd0);
    chk("cmd0_cyc", s_cyc, {8'd0, 8'd10, 8'd1, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1});
    @(negedge clk);
    chk("cmd0_run_start", 80'(s_start), 80'd1);
    wait_init();
    chk("hc_init_done", 80'({init_done, init_err}), 80'b10);
    chk("hc_sdhc", 80'(sdhc), 80'd1);
    chk("hc_acmd41_n", 80'(n_acmd41), 80'd3);
    chk("hc_cmd58_n", 80'(n_cmd58), 80'd1);
    chk("hc_acmd_frame", 80'(last_acmd), 80'h69_4000_0000_77);
    do_read(32'h0000_1234, 1'b0);
    chk("hc_read_arg", 80'(last_read_arg), 80'h1234);

    // bad data token
    cfg_token = 8'hFC;
    do_read(32'd5, 1'b1);
    cfg_token = 8'hFE;

    // reset during ACMD41, then CMD0 retry budget must be whole again
    cfg_cmd0_fail_n = 5; cfg_busy_n = 100;
    do_reset();
    for (int t = 0; t < 2000; t++) begin
      if (s_start && s_cmd[47:40] == 8'h77) break;
      @(negedge clk);
    end
    chk("in_acmd41", 80'(s_cmd[47:40]), 80'h77);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_start", 80'(s_start), 80'd0);
    @(negedge clk);
    cfg_cmd0_fail_n = 7; cfg_busy_n = 1;
    rst = 1'b0;
    @(negedge clk);
    chk("restart_cmd0", 80'(s_cmd), 80'h40_0000_0000_95);
    wait_init();
    chk("retry_init_done", 80'({init_done, init_err}), 80'b10);
    chk("retry_cmd0_n", 80'(n_cmd0), 80'd8);

    // v1 card: CMD58 skipped, byte addressing
    cfg_cmd0_fail_n = 0; cfg_busy_n = 0; cfg_v1 = 1'b1;
    do_reset();
    wait_init();
    chk("v1_init_done", 80'({init_done, init_err}), 80'b10);
    chk("v1_sdhc", 80'(sdhc), 80'd0);
    chk("v1_cmd58_n", 80'(n_cmd58), 80'd0);
    chk("v1_acmd41_n", 80'(n_acmd41), 80'd1);
    chk("v1_acmd_frame", 80'(last_acmd), 80'h69_0000_0000_E5);
    do_read(32'd3, 1'b0);
    chk("v1_read_arg", 80'(last_read_arg), 80'h0000_0600);

    // dead card: CMD0 never answers
    cfg_v1 = 1'b0; cfg_cmd0_fail_n = 1000;
    do_reset();
    wait_init();
    chk("dead_init", 80'({init_done, init_err}), 80'b01);
    chk("dead_cmd0_n", 80'(n_cmd0), 80'd8);
    repeat (50) @(negedge clk);
    chk("dead_cmd0_n_held", 80'(n_cmd0), 80'd8);
    chk("dead_busy", 80'(busy), 80'd1);
    chk("dead_err_sticky", 80'(init_err), 80'd1);
    rd_req = 1'b1; rd_addr = 32'd9;
    #1;
    chk("dead_no_ack", 80'(rd_ack), 80'd0);
    @(negedge clk);
    rd_req = 1'b0;
    chk("dead_no_start", 80'(s_start), 80'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
